// File: rtl/apb_protocol_if.sv
// rtl/apb_protocol_if.sv - APB master/slave bus signal bundle for apb_protocol
//
// Groups the transfer-control, address, data, slave-select and UART rx
// signals of apb_protocol.
// The master modport drives the request side and the rx line.
// The slave modport sees those signals as inputs and drives apb_readData_out.
// Clock and reset are not part of the bundle.

interface apb_protocol_if;
    logic        PENABLE;
    logic        PWRITE;
    logic        transfer;
    logic [4:0]  apb_writeAddr;
    logic [4:0]  apb_readAddr;
    logic [31:0] apb_writeData;
    logic [1:0]  PSEL;
    logic [31:0] apb_readData_out;
    logic        rx;

    modport master (
        output PENABLE, PWRITE, transfer, apb_writeAddr, apb_readAddr,
        output apb_writeData, PSEL, rx,
        input  apb_readData_out
    );

    modport slave (
        input  PENABLE, PWRITE, transfer, apb_writeAddr, apb_readAddr,
        input  apb_writeData, PSEL, rx,
        output apb_readData_out
    );
endinterface

// File: rtl/apb_protocol.sv
// rtl/apb_protocol.sv - APB master FSM with GPIO register file and UART receive slave
//
// Ports:
//   PCLK              clock; all state updates on its rising edge
//   PENABLE           access-phase enable; 1 completes the pending transfer
//   PWRITE            1 = write, 0 = read
//   transfer          request to start or continue transfers
//   PRESETn           asynchronous active-low reset
//   apb_writeAddr     register address used for writes
//   apb_readAddr      register address used for reads
//   apb_writeData     write data
//   PSEL              01 = GPIO, 10 = UART, 00/11 = no slave
//   apb_readData_out  registered read data
//   rx                UART serial receive line (idles high)

module apb_protocol (
    input  logic        PCLK,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic        transfer,
    input  logic        PRESETn,
    input  logic [4:0]  apb_writeAddr,
    input  logic [4:0]  apb_readAddr,
    input  logic [31:0] apb_writeData,
    input  logic [1:0]  PSEL,
    output logic [31:0] apb_readData_out,
    input  logic        rx
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    state_t      state, state_next;
    logic        latch_en;
    logic        complete;

    logic [1:0]  lat_sel;
    logic        lat_write;
    logic [4:0]  lat_addr;
    logic [31:0] lat_data;

    logic [31:0] gpio [32];

    logic [15:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        overrun;

    logic        rx_meta, rx_sync, rx_prev;
    rx_state_t   rx_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    logic [15:0] baud_eff;
    logic [15:0] half_cnt;
    logic        bit_end;
    logic        frame_ok;

    logic        wr_gpio, wr_uart, rd_done;
    logic        clr_valid, clr_ovr;
    logic [31:0] uart_rd;
    logic [31:0] rd_mux;

    // ---------------- master FSM ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PENABLE) state_next = transfer ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state == SETUP);
        complete = (state == ACCESS) && PENABLE;
    end

    // Request captured during SETUP so the access phase works on a stable copy.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lat_sel   <= 2'b00;
            lat_write <= 1'b0;
            lat_addr  <= 5'd0;
            lat_data  <= 32'd0;
        end else if (latch_en) begin
            lat_sel   <= PSEL;
            lat_write <= PWRITE;
            lat_addr  <= PWRITE ? apb_writeAddr : apb_readAddr;
            lat_data  <= apb_writeData;
        end
    end

    assign wr_gpio   = complete &&  lat_write && (lat_sel == 2'b01);
    assign wr_uart   = complete &&  lat_write && (lat_sel == 2'b10);
    assign rd_done   = complete && !lat_write;
    assign clr_valid = rd_done && (lat_sel == 2'b10) && (lat_addr == 5'h00);
    assign clr_ovr   = rd_done && (lat_sel == 2'b10) && (lat_addr == 5'h01);

    // ---------------- GPIO register file ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 32; i++) gpio[i] <= 32'd0;
        end else if (wr_gpio) begin
            gpio[lat_addr] <= lat_data;
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        uart_rd = 32'd0;
        case (lat_addr)
            5'h00:   uart_rd = {24'd0, rx_data};
            5'h01:   uart_rd = {30'd0, overrun, rx_valid};
            5'h02:   uart_rd = {16'd0, baud_div};
            default: uart_rd = 32'd0;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (lat_sel)
            2'b01:   rd_mux = gpio[lat_addr];
            2'b10:   rd_mux = uart_rd;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     apb_readData_out <= 32'd0;
        else if (rd_done) apb_readData_out <= rd_mux;
    end

    // ---------------- UART BAUD_DIV ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                            baud_div <= 16'd16;
        else if (wr_uart && lat_addr == 5'h02)   baud_div <= lat_data[15:0];
    end

    // A divider of 0 behaves as 1; half_cnt is the last count of the
    // half-bit wait before the start bit is rechecked.
    always_comb begin
        baud_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
        half_cnt = (baud_eff[15:1] == 15'd0) ? 16'd0 : {1'b0, baud_eff[15:1]} - 16'd1;
        bit_end  = (bit_cnt >= baud_eff - 16'd1);
        frame_ok = (rx_state == R_STOP) && bit_end && rx_sync;
    end

    // ---------------- UART receiver ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= R_START;
                        bit_cnt  <= 16'd0;
                    end
                end
                R_START: begin
                    if (bit_cnt >= half_cnt) begin
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        // A line back high at mid start bit was a glitch.
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= R_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (bit_end) begin
                        bit_cnt  <= 16'd0;
                        rx_state <= R_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase

            if (clr_valid) rx_valid <= 1'b0;
            if (clr_ovr)   overrun  <= 1'b0;
            // A byte landing on the same edge as a clearing read takes priority.
            if (frame_ok) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_valid) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_protocol.sv
// tb/tb_apb_protocol.sv - self-checking bench for apb_protocol

module tb_apb_protocol;

    typedef struct {
        logic [1:0]  sel;
        logic        wr;
        logic [4:0]  waddr;
        logic [4:0]  raddr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic PCLK;
    logic PRESETn;
    apb_protocol_if bus();

    apb_protocol dut (
        .PCLK             (PCLK),
        .PENABLE          (bus.PENABLE),
        .PWRITE           (bus.PWRITE),
        .transfer         (bus.transfer),
        .PRESETn          (PRESETn),
        .apb_writeAddr    (bus.apb_writeAddr),
        .apb_readAddr     (bus.apb_readAddr),
        .apb_writeData    (bus.apb_writeData),
        .PSEL             (bus.PSEL),
        .apb_readData_out (bus.apb_readData_out),
        .rx               (bus.rx)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    vec_t        tbl [20];

    function automatic vec_t mk(input logic [1:0] s, input logic w, input logic [4:0] wa,
                                input logic [4:0] ra, input logic [31:0] wd, input logic [31:0] ex);
        vec_t v;
        v.sel = s; v.wr = w; v.waddr = wa; v.raddr = ra; v.wdata = wd; v.exp = ex;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Entered from IDLE at posedge+1; leaves the FSM in IDLE at posedge+1.
    task automatic apb_xfer(input string name, input vec_t v, input int waits);
        logic [31:0] e;
        bus.PSEL          = v.sel;
        bus.PWRITE        = v.wr;
        bus.apb_writeAddr = v.waddr;
        bus.apb_readAddr  = v.raddr;
        bus.apb_writeData = v.wdata;
        bus.PENABLE       = 1'b1;
        bus.transfer      = 1'b1;
        if (!v.wr) exp_q.push_back(v.exp);
        @(posedge PCLK);
        @(posedge PCLK);
        #1 bus.transfer = 1'b0;
        if (waits > 0) begin
            bus.PENABLE = 1'b0;
            repeat (waits) begin
                @(posedge PCLK);
                #1 check("wait_hold", bus.apb_readData_out, last_rd);
            end
            bus.PENABLE = 1'b1;
        end
        @(posedge PCLK);
        #1;
        if (!v.wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s: scoreboard empty got %08h expected none", name, bus.apb_readData_out);
            end else begin
                e = exp_q.pop_front();
                check(name, bus.apb_readData_out, e);
                last_rd = e;
            end
        end else begin
            check({name, "_hold"}, bus.apb_readData_out, last_rd);
        end
    endtask

    task automatic uart_read(input string name, input logic [4:0] a, input logic [31:0] ex);
        apb_xfer(name, mk(2'b10, 1'b0, 5'd0, a, 32'd0, ex), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (16) @(posedge PCLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (16) @(posedge PCLK);
            #1;
        end
        bus.rx = stop;
        repeat (16) @(posedge PCLK);
        #1 bus.rx = 1'b1;
        repeat (24) @(posedge PCLK);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(2'b01, 1'b1, 5'd1,  5'd9,  32'hABCD1234, 32'h0);
        tbl[1]  = mk(2'b01, 1'b0, 5'd9,  5'd1,  32'h0,        32'hABCD1234);
        tbl[2]  = mk(2'b01, 1'b1, 5'd2,  5'd1,  32'h00000AAA, 32'h0);
        tbl[3]  = mk(2'b01, 1'b0, 5'd1,  5'd2,  32'h0,        32'h00000AAA);
        tbl[4]  = mk(2'b01, 1'b0, 5'd2,  5'd1,  32'h0,        32'hABCD1234);
        tbl[5]  = mk(2'b00, 1'b0, 5'd0,  5'd1,  32'h0,        32'h0);
        tbl[6]  = mk(2'b11, 1'b1, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0);
        tbl[7]  = mk(2'b11, 1'b0, 5'd0,  5'd3,  32'h0,        32'h0);
        tbl[8]  = mk(2'b01, 1'b0, 5'd0,  5'd3,  32'h0,        32'h0);
        tbl[9]  = mk(2'b01, 1'b1, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0);
        tbl[10] = mk(2'b01, 1'b0, 5'd0,  5'd31, 32'h0,        32'hFFFFFFFF);
        tbl[11] = mk(2'b10, 1'b1, 5'd2,  5'd0,  32'hFFFF0020, 32'h0);
        tbl[12] = mk(2'b10, 1'b0, 5'd0,  5'd2,  32'h0,        32'h00000020);
        tbl[13] = mk(2'b10, 1'b1, 5'd0,  5'd0,  32'h12345678, 32'h0);
        tbl[14] = mk(2'b10, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0);
        tbl[15] = mk(2'b10, 1'b1, 5'd5,  5'd0,  32'h11111111, 32'h0);
        tbl[16] = mk(2'b10, 1'b0, 5'd0,  5'd5,  32'h0,        32'h0);
        tbl[17] = mk(2'b10, 1'b1, 5'd2,  5'd0,  32'h00000010, 32'h0);
        tbl[18] = mk(2'b10, 1'b0, 5'd0,  5'd2,  32'h0,        32'h00000010);
        tbl[19] = mk(2'b10, 1'b0, 5'd0,  5'd1,  32'h0,        32'h0);

        PRESETn           = 1'b0;
        bus.PENABLE       = 1'b0;
        bus.PWRITE        = 1'b0;
        bus.transfer      = 1'b0;
        bus.apb_writeAddr = 5'd0;
        bus.apb_readAddr  = 5'd0;
        bus.apb_writeData = 32'd0;
        bus.PSEL          = 2'b00;
        bus.rx            = 1'b1;
        last_rd           = 32'd0;

        repeat (3) @(posedge PCLK);
        #1 check("reset_rdata", bus.apb_readData_out, 32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        for (int i = 0; i < 20; i++) apb_xfer($sformatf("vec%0d", i), tbl[i], 0);

        // Wait states in ACCESS must leave the output untouched.
        apb_xfer("pre_wait_rd", mk(2'b01, 1'b0, 5'd0, 5'd1, 32'h0, 32'hABCD1234), 0);
        apb_xfer("wait_rd",     mk(2'b01, 1'b0, 5'd0, 5'd2, 32'h0, 32'h00000AAA), 3);

        // Single byte, then status clears after the data read.
        send_byte(8'hA5, 1'b1);
        uart_read("status_one",  5'h01, 32'h1);
        uart_read("rx_data_a5",  5'h00, 32'h000000A5);
        uart_read("status_zero", 5'h01, 32'h0);

        // Two bytes without a read: overrun, last byte kept.
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
        uart_read("status_ovr",  5'h01, 32'h3);
        uart_read("rx_data_5a",  5'h00, 32'h0000005A);
        uart_read("status_clr",  5'h01, 32'h0);

        // Bad stop bit: frame dropped.
        send_byte(8'h77, 1'b0);
        uart_read("badstop_status", 5'h01, 32'h0);
        uart_read("badstop_data",   5'h00, 32'h0000005A);

        // Short low glitch: start recheck aborts.
        bus.rx = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 bus.rx = 1'b1;
        repeat (40) @(posedge PCLK);
        #1;
        uart_read("glitch_status", 5'h01, 32'h0);

        // Reset asserted in ACCESS aborts the pending write.
        apb_xfer("baud8_wr", mk(2'b10, 1'b1, 5'd2, 5'd0, 32'h00000008, 32'h0), 0);
        apb_xfer("baud8_rd", mk(2'b10, 1'b0, 5'd0, 5'd2, 32'h0, 32'h00000008), 0);
        apb_xfer("pre_rst_rd", mk(2'b01, 1'b0, 5'd0, 5'd1, 32'h0, 32'hABCD1234), 0);
        bus.PSEL          = 2'b01;
        bus.PWRITE        = 1'b1;
        bus.apb_writeAddr = 5'd4;
        bus.apb_writeData = 32'h12345678;
        bus.PENABLE       = 1'b0;
        bus.transfer      = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        #1 bus.transfer = 1'b0;
        #2 PRESETn = 1'b0;
        #1 check("rst_async_rdata", bus.apb_readData_out, 32'h0);
        bus.PENABLE = 1'b1;
        @(posedge PCLK);
        #1 check("rst_held_rdata", bus.apb_readData_out, 32'h0);
        PRESETn = 1'b1;
        last_rd = 32'h0;
        @(posedge PCLK);
        #1;
        apb_xfer("post_rst_gpio4", mk(2'b01, 1'b0, 5'd0, 5'd4, 32'h0, 32'h0), 0);
        apb_xfer("post_rst_gpio1", mk(2'b01, 1'b0, 5'd0, 5'd1, 32'h0, 32'h0), 0);
        uart_read("post_rst_baud", 5'h02, 32'h00000010);
        uart_read("post_rst_data", 5'h00, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
